cacheline_burst_adapter: RTL
============================

// Module: cacheline_burst_adapter
// PURPOSE
//  Memory-side responder for the cache datapath's 256-bit line interface.
//  Accepts a whole-line read (fill) or write (writeback) from the cache controller.
//  Performs it as BEATS sequential 64-bit beats on the physical memory burst bus.
//  Returns a single-cycle resp_o, with line_o valid on reads.
//  Sits between cache_datapath_4/controller and main memory or the arbiter.
// PARAMETERS
//  LINE_W   256  cache line width in bits
//  BURST_W  64   memory beat width in bits; BEATS = LINE_W/BURST_W = 4
//  ADDR_W   32   address width; line-aligned addresses (low 5 bits zero)
// PORTS
//  clk        in   1        system clock; all state on rising edge
//  rst        in   1        reset, asynchronous, active-low
//  read_i     in   1        cache requests line fill; held until resp_o seen
//  write_i    in   1        cache requests line writeback; held until resp_o seen
//  address_i  in   ADDR_W   line address (new_address from datapath)
//  line_i     in   LINE_W   line to write (cacheline_out from datapath)
//  line_o     out  LINE_W   assembled fill line (to cacheline_in)
//  resp_o     out  1        1-cycle completion pulse to cache
//  address_o  out  ADDR_W   latched line address to memory
//  read_o     out  1        memory burst read request
//  write_o    out  1        memory burst write request
//  burst_o    out  BURST_W  current write beat
//  burst_i    in   BURST_W  current read beat
//  resp_i     in   1        memory accepts/returns one beat this cycle
// BEHAVIOUR
//  Reset (async, rst=0):
//   - state=IDLE, beat counter=0.
//   - resp_o, read_o, write_o=0; address_o, burst_o, line_o, line buffer=0.
//   - Reset mid-burst aborts the burst with no resp_o.
//  FSM states: IDLE, READ, WRITE, DONE.
//  IDLE:
//   - write_i=1 -> latch address_i and line_i; go to WRITE.
//   - else read_i=1 -> latch address_i; go to READ.
//   - write_i wins if both are high. resp_i is ignored.
//  READ:
//   - read_o=1; address_o holds the latched address.
//   - On each resp_i=1: buf[cnt*BURST_W +: BURST_W] <= burst_i, cnt++.
//   - resp_i=1 with cnt==BEATS-1 -> DONE, cnt<=0.
//  WRITE:
//   - write_o=1; burst_o = latched line[cnt*BURST_W +: BURST_W] (combinational on cnt).
//   - On each resp_i=1: cnt++.
//   - resp_i=1 with cnt==BEATS-1 -> DONE, cnt<=0.
//  Beat gaps: resp_i may drop mid-burst; the counter holds and the outputs stay steady.
//   No timeout.
//  DONE:
//   - resp_o=1 for exactly this cycle; read_o=write_o=0; next state is IDLE.
//   - line_o is updated from buf on entry to DONE (reads only).
//   - line_o holds until the next read completes; writes never change line_o.
//  Request drop: the cache drops read_i/write_i the cycle after resp_o, so IDLE
//   does not restart. A request still high in IDLE starts a new transaction.
//  Minimum latency: request sampled at edge 0; DONE after 4 back-to-back beats.
//   resp_o is high in cycle 6 (1 latch + 4 beats + 1 DONE).
//  address_o, read_o, write_o and burst_o must not change between beats of a burst.
//   address_i/line_i changes mid-burst are ignored.
//  read_o and write_o are never both 1.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles with read_i=1 -> all outputs 0, no read_o.
//     Release -> read_o=1 on the 2nd edge.
//  2. Fill, back-to-back: read_i, address_i=0x0000_1A40; beats
//     0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i.
//     -> line_o={0x44..,0x33..,0x22..,0x11..}, resp_o single pulse 6 cycles after
//     request, address_o=0x0000_1A40 throughout.
//  3. Writeback with gaps: write_i, line_i=0xDDCCBBAA pattern per beat, resp_i
//     pattern 1,0,0,1,1,0,1.
//     -> burst_o steps beat0..3 only after each resp_i=1; resp_o after the 4th
//     accept; line_o unchanged.
//  4. Simultaneous read_i=write_i=1 in IDLE -> write_o asserted, read_o stays 0.
//     A following read request is served normally.
//  5. Reset mid-read after 2 beats -> outputs 0 immediately (async), no resp_o.
//     Next fill starts at beat 0 and returns correct data.
//  6. Spurious resp_i=1 in IDLE for 5 cycles -> no state change, cnt stays 0.
//     The next fill is correct.

Source files
------------

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter
// Memory-side responder for a 256-bit cache line interface. A whole-line fill
// or writeback is carried out as BEATS sequential beats on the memory burst
// bus. When the transaction finishes, the cache sees a single-cycle resp_o.
module cacheline_burst_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W = $clog2(LINE_W);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [LINE_W-1:0]   wline_reg;     // line captured for a writeback
  logic [LINE_W-1:0]   buf_reg;       // fill line under assembly
  logic [LINE_W-1:0]   buf_next;
  logic [LINE_W-1:0]   line_out_reg;  // last completed fill line
  logic [IDX_W-1:0]    beat_base;
  logic                last_beat;

  assign beat_base = IDX_W'(cnt_reg) * IDX_W'(BURST_W);
  assign last_beat = (cnt_reg == CNT_W'(BEATS - 1));
  assign address_o = addr_reg;
  assign line_o    = line_out_reg;

  // Fill buffer with the beat arriving this cycle merged in. The last beat
  // goes straight into line_o through this path on the edge into DONE.
  always_comb begin
    buf_next = buf_reg;
    if (state_reg == READ && resp_i) begin
      buf_next[beat_base +: BURST_W] = burst_i;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and bus outputs. The outputs are decoded from the state
  // alone, so they remain steady across gaps between beats.
  always_comb begin
    state_next = state_reg;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    burst_o    = '0;
    case (state_reg)
      IDLE: begin
        if (write_i) begin
          state_next = WRITE;
        end else if (read_i) begin
          state_next = READ;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i && last_beat) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = wline_reg[beat_base +: BURST_W];
        if (resp_i && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, beat counting and fill assembly. The address and write
  // line are latched only in IDLE, so changes to the request inputs during a
  // burst have no effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wline_reg    <= '0;
      buf_reg      <= '0;
      line_out_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (write_i) begin
            addr_reg  <= address_i;
            wline_reg <= line_i;
          end else if (read_i) begin
            addr_reg <= address_i;
          end
        end
        READ: begin
          if (resp_i) begin
            buf_reg <= buf_next;
            if (last_beat) begin
              cnt_reg      <= '0;
              line_out_reg <= buf_next;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            if (last_beat) begin
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
